// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the five-stage RV32I pipeline.
// Tracks E/M/W in a private scoreboard and drives stall, flush, freeze and forwarding selects.
module hazard_ctrl #(
  parameter int AW       = 5,
  parameter int FWD_EN   = 1,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_d,
  input  logic [AW-1:0]    rs2_d,
  input  logic             rs1_used_d,
  input  logic             rs2_used_d,
  input  logic [AW-1:0]    rd_d,
  input  logic             reg_write_d,
  input  logic             load_d,
  input  logic             pc_src_e,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          reg_write;
    logic          load;
  } entry_t;

  entry_t          e_q, m_q, w_q;
  logic [AW-1:0]   rs1_e_q, rs2_e_q;
  logic [WW-1:0]   wait_q;
  logic            timeout_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, freeze_cnt_q;

  logic frz, flush, raw_stall, hit_e, hit_m;

  function automatic logic produces(input entry_t x);
    return x.valid & x.reg_write & (x.rd != '0);
  endfunction

  // M-stage load results are not forwardable yet; only W may supply them.
  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src, input entry_t m, input entry_t w);
    if (FWD_EN == 0)                           return 2'b00;
    else if (produces(m) && !m.load && m.rd == src) return 2'b10;
    else if (produces(w) && w.rd == src)        return 2'b01;
    else                                        return 2'b00;
  endfunction

  always_comb begin
    hit_e = produces(e_q) & ((rs1_used_d & (rs1_d == e_q.rd)) | (rs2_used_d & (rs2_d == e_q.rd)));
    hit_m = produces(m_q) & ((rs1_used_d & (rs1_d == m_q.rd)) | (rs2_used_d & (rs2_d == m_q.rd)));
    frz   = m_q.valid & m_q.load & ~mem_ready;
    flush = ~frz & pc_src_e;
    if (FWD_EN != 0) raw_stall = ~frz & ~pc_src_e & hit_e & e_q.load;
    else             raw_stall = ~frz & ~pc_src_e & (hit_e | hit_m);
  end

  assign stall_f     = ~rst & (frz | raw_stall);
  assign stall_d     = ~rst & (frz | raw_stall);
  assign stall_e     = ~rst & frz;
  assign flush_d     = ~rst & flush;
  assign flush_e     = ~rst & (flush | raw_stall);
  assign forward_ae  = rst ? 2'b00 : fwd_sel(rs1_e_q, m_q, w_q);
  assign forward_be  = rst ? 2'b00 : fwd_sel(rs2_e_q, m_q, w_q);
  assign mem_timeout = ~rst & timeout_q;
  assign stall_cnt   = rst ? '0 : stall_cnt_q;
  assign flush_cnt   = rst ? '0 : flush_cnt_q;
  assign freeze_cnt  = rst ? '0 : freeze_cnt_q;

  // Scoreboard shifts with the datapath; a freeze holds every stage in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q          <= '0;
      m_q          <= '0;
      w_q          <= '0;
      rs1_e_q      <= '0;
      rs2_e_q      <= '0;
      wait_q       <= '0;
      timeout_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      if (!frz) begin
        w_q           <= m_q;
        m_q           <= e_q;
        e_q.valid     <= ~(flush | raw_stall);
        e_q.rd        <= rd_d;
        e_q.reg_write <= reg_write_d;
        e_q.load      <= load_d;
        rs1_e_q       <= rs1_d;
        rs2_e_q       <= rs2_d;
        wait_q        <= '0;
      end else begin
        if (wait_q != WW'(MAX_WAIT)) wait_q <= wait_q + 1'b1;
        if (wait_q == WAIT_LAST) timeout_q <= 1'b1;
      end
      if (raw_stall && stall_cnt_q != '1)  stall_cnt_q  <= stall_cnt_q + 1'b1;
      if (flush && flush_cnt_q != '1)      flush_cnt_q  <= flush_cnt_q + 1'b1;
      if (frz && freeze_cnt_q != '1)       freeze_cnt_q <= freeze_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: default, stall-only and 2-bit-counter instances share stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       rs1_used_d, rs2_used_d, reg_write_d, load_d, pc_src_e, mem_ready;

  logic        sf, sd, se, fd, fe, mto;
  logic [1:0]  fa, fb;
  logic [15:0] scnt, fcnt, zcnt;

  logic        n_sf, n_sd, n_se, n_fd, n_fe, n_mto;
  logic [1:0]  n_fa, n_fb;
  logic [15:0] n_scnt, n_fcnt, n_zcnt;

  logic        c_sf, c_sd, c_se, c_fd, c_fe, c_mto;
  logic [1:0]  c_fa, c_fb;
  logic [1:0]  c_scnt, c_fcnt, c_zcnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(5), .FWD_EN(1), .MAX_WAIT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
    .rs2_used_d(rs2_used_d), .rd_d(rd_d), .reg_write_d(reg_write_d), .load_d(load_d),
    .pc_src_e(pc_src_e), .mem_ready(mem_ready), .stall_f(sf), .stall_d(sd), .stall_e(se),
    .flush_d(fd), .flush_e(fe), .forward_ae(fa), .forward_be(fb), .mem_timeout(mto),
    .stall_cnt(scnt), .flush_cnt(fcnt), .freeze_cnt(zcnt));

  hazard_ctrl #(.AW(5), .FWD_EN(0), .MAX_WAIT(15), .CNT_W(16)) dut_nf (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
    .rs2_used_d(rs2_used_d), .rd_d(rd_d), .reg_write_d(reg_write_d), .load_d(load_d),
    .pc_src_e(pc_src_e), .mem_ready(mem_ready), .stall_f(n_sf), .stall_d(n_sd), .stall_e(n_se),
    .flush_d(n_fd), .flush_e(n_fe), .forward_ae(n_fa), .forward_be(n_fb), .mem_timeout(n_mto),
    .stall_cnt(n_scnt), .flush_cnt(n_fcnt), .freeze_cnt(n_zcnt));

  hazard_ctrl #(.AW(5), .FWD_EN(1), .MAX_WAIT(15), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used_d(rs1_used_d),
    .rs2_used_d(rs2_used_d), .rd_d(rd_d), .reg_write_d(reg_write_d), .load_d(load_d),
    .pc_src_e(pc_src_e), .mem_ready(mem_ready), .stall_f(c_sf), .stall_d(c_sd), .stall_e(c_se),
    .flush_d(c_fd), .flush_e(c_fe), .forward_ae(c_fa), .forward_be(c_fb), .mem_timeout(c_mto),
    .stall_cnt(c_scnt), .flush_cnt(c_fcnt), .freeze_cnt(c_zcnt));

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                               input logic [4:0] rdv, input logic rw, input logic ld,
                               input logic pc, input logic mr);
    rs1_d = r1; rs1_used_d = u1; rs2_d = r2; rs2_used_d = u2;
    rd_d = rdv; reg_write_d = rw; load_d = ld; pc_src_e = pc; mem_ready = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic mr);
    applyStimulus(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, mr);
  endtask

  task automatic doReset();
    rst = 1'b1;
    nop(1'b1);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    nop(1'b1);
    tick();
    checkOutput("rst_stall_f", 32'(sf), 32'd0);
    checkOutput("rst_flush_e", 32'(fe), 32'd0);
    checkOutput("rst_fwd_a", 32'(fa), 32'd0);
    checkOutput("rst_cnt", 32'(scnt), 32'd0);
    rst = 1'b0;

    // ALU RAW: add x5 ; sub x6,x5,x1 -> M forward
    applyStimulus(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 1); tick();
    applyStimulus(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0, 1);
    checkOutput("alu_nostall", 32'(sd), 32'd0);
    tick();
    nop(1'b1);
    checkOutput("alu_fwd_a_m", 32'(fa), 32'd2);
    checkOutput("alu_fwd_b", 32'(fb), 32'd0);
    tick();
    // add x9 ; addi x10 ; sub x11,x9,x3 -> W forward
    applyStimulus(5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0, 1); tick();
    applyStimulus(5'd0, 1, 5'd0, 0, 5'd10, 1, 0, 0, 1); tick();
    applyStimulus(5'd9, 1, 5'd3, 1, 5'd11, 1, 0, 0, 1); tick();
    nop(1'b1);
    checkOutput("alu_fwd_a_w", 32'(fa), 32'd1);
    checkOutput("alu_fwd_b_w", 32'(fb), 32'd0);
    checkOutput("alu_scnt", 32'(scnt), 32'd0);
    tick();

    // Load-use: lw x7 ; add x8,x7,x7
    doReset();
    applyStimulus(5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 1); tick();
    applyStimulus(5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0, 1);
    checkOutput("lu_stall_f", 32'(sf), 32'd1);
    checkOutput("lu_stall_d", 32'(sd), 32'd1);
    checkOutput("lu_flush_e", 32'(fe), 32'd1);
    checkOutput("lu_stall_e", 32'(se), 32'd0);
    checkOutput("lu_flush_d", 32'(fd), 32'd0);
    tick();
    checkOutput("lu_release", 32'(sf), 32'd0);
    tick();
    nop(1'b1);
    checkOutput("lu_fwd_a", 32'(fa), 32'd1);
    checkOutput("lu_fwd_b", 32'(fb), 32'd1);
    checkOutput("lu_scnt", 32'(scnt), 32'd1);
    tick();

    // Branch flush concurrent with load-use match
    doReset();
    applyStimulus(5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 1); tick();
    applyStimulus(5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 1, 1);
    checkOutput("br_flush_d", 32'(fd), 32'd1);
    checkOutput("br_flush_e", 32'(fe), 32'd1);
    checkOutput("br_stall_d", 32'(sd), 32'd0);
    checkOutput("br_stall_f", 32'(sf), 32'd0);
    tick();
    nop(1'b1);
    checkOutput("br_fcnt", 32'(fcnt), 32'd1);
    checkOutput("br_scnt", 32'(scnt), 32'd0);
    tick();

    // Memory wait: lw x7 ; add x12,x1,x2 ; 3 freeze cycles ; sub x14,x12,x7
    doReset();
    applyStimulus(5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 1); tick();
    applyStimulus(5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      nop(1'b0);
      checkOutput($sformatf("frz_stall_e%0d", i), 32'(se), 32'd1);
      checkOutput($sformatf("frz_stall_f%0d", i), 32'(sf), 32'd1);
      checkOutput($sformatf("frz_flush_e%0d", i), 32'(fe), 32'd0);
      tick();
    end
    applyStimulus(5'd12, 1, 5'd7, 1, 5'd14, 1, 0, 0, 1);
    checkOutput("frz_done", 32'(se), 32'd0);
    checkOutput("frz_zcnt", 32'(zcnt), 32'd3);
    checkOutput("frz_timeout0", 32'(mto), 32'd0);
    tick();
    applyStimulus(5'd1, 1, 5'd0, 0, 5'd15, 1, 1, 0, 1);
    checkOutput("frz_held_fwd_a", 32'(fa), 32'd2);
    checkOutput("frz_held_fwd_b", 32'(fb), 32'd1);
    tick();
    nop(1'b1); tick();
    for (int i = 0; i < 15; i++) begin
      nop(1'b0);
      if (i == 14) checkOutput("to_before", 32'(mto), 32'd0);
      tick();
    end
    nop(1'b1);
    checkOutput("to_set", 32'(mto), 32'd1);
    checkOutput("to_zcnt", 32'(zcnt), 32'd18);
    tick(); tick();
    checkOutput("to_sticky", 32'(mto), 32'd1);
    doReset();
    checkOutput("to_cleared", 32'(mto), 32'd0);

    // Stall-only mode: addi x3 ; add x4,x3,x0
    doReset();
    applyStimulus(5'd0, 1, 5'd0, 0, 5'd3, 1, 0, 0, 1); tick();
    applyStimulus(5'd3, 1, 5'd0, 1, 5'd4, 1, 0, 0, 1);
    checkOutput("nf_stall1", 32'(n_sf), 32'd1);
    checkOutput("nf_flush_e1", 32'(n_fe), 32'd1);
    checkOutput("nf_fwd1", 32'({n_fa, n_fb}), 32'd0);
    tick();
    checkOutput("nf_stall2", 32'(n_sd), 32'd1);
    tick();
    checkOutput("nf_release", 32'(n_sf), 32'd0);
    tick();
    nop(1'b1);
    checkOutput("nf_fwd_e", 32'({n_fa, n_fb}), 32'd0);
    checkOutput("nf_scnt", 32'(n_scnt), 32'd2);
    tick();
    applyStimulus(5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0, 1); tick();
    applyStimulus(5'd0, 1, 5'd0, 1, 5'd16, 1, 0, 0, 1);
    checkOutput("nf_x0_nostall", 32'(n_sf), 32'd0);
    tick();

    // Reset asserted mid-freeze
    doReset();
    applyStimulus(5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 1); tick();
    nop(1'b1); tick();
    nop(1'b0);
    checkOutput("rf_frozen", 32'(se), 32'd1);
    tick();
    rst = 1'b1;
    nop(1'b0);
    checkOutput("rf_during_rst", 32'(se), 32'd0);
    tick();
    rst = 1'b0;
    nop(1'b0);
    checkOutput("rf_stall_e", 32'(se), 32'd0);
    checkOutput("rf_stall_f", 32'(sf), 32'd0);
    checkOutput("rf_zcnt", 32'(zcnt), 32'd0);
    tick();

    // Counter saturation: five load-use stalls
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 1); tick();
      applyStimulus(5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0, 1);
      checkOutput($sformatf("sat_stall%0d", i), 32'(c_sf), 32'd1);
      tick();
      tick();
    end
    nop(1'b1);
    checkOutput("sat_c2", 32'(c_scnt), 32'd3);
    checkOutput("sat_c16", 32'(scnt), 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
